// File: rtl/decryption.sv
// decryption: five-stage inverse of the encryption pipeline. Key travels with its word, and the block counts delivered words.
// Latency: a word accepted at edge t is presented after edge t+4. Throughput is one word per cycle.
// Backpressure: bubble-collapsing valid/ready. A stage loads whenever it is empty or its successor moves.
module decryption #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     e_data,
  input  logic [N-1:0]     key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     d_data,
  output logic [CNT_W-1:0] dec_count
);

  localparam int H = N / 2;

  // Stage state: index 0 is S1 ... index 4 is S5.
  // S5 needs no key because the XOR is already applied when S5 loads.
  logic [4:0]          vld_q;
  logic [4:0][N-1:0]   wrd_q;
  logic [3:0][N-1:0]   key_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [4:0]          rdy;
  logic [4:0]          vld_d;
  logic [4:0][N-1:0]   wrd_d;
  logic [3:0][N-1:0]   key_d;

  function automatic logic [N-1:0] swap_f(input logic [N-1:0] x);
    return {x[H-1:0], x[N-1:H]};
  endfunction

  function automatic logic [N-1:0] rev_f(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = x[N-1-i];
    return r;
  endfunction

  // A stage may load when out_ready is high or any stage from it down to S5 is empty.
  // Each ready term is computed directly, so the chain has no self-referencing vector.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < 5; i++) begin
      logic acc;
      acc = out_ready;
      for (int j = i; j < 5; j++) acc = acc | ~vld_q[j];
      rdy[i] = acc;
    end
  end

  // Candidate contents for each stage, taken from its predecessor.
  always_comb begin
    vld_d    = {vld_q[3:0], in_valid};
    key_d    = {key_q[2:0], key};
    wrd_d    = '0;
    wrd_d[0] = swap_f(e_data);
    wrd_d[1] = rev_f(wrd_q[0]);
    wrd_d[2] = ~wrd_q[1];
    wrd_d[3] = swap_f(wrd_q[2]);
    wrd_d[4] = wrd_q[3] ^ key_q[3];
  end

  // Stage registers: load when ready, otherwise hold every field.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      wrd_q <= '0;
      key_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (rdy[i]) begin
          vld_q[i] <= vld_d[i];
          wrd_q[i] <= wrd_d[i];
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) key_q[i] <= key_d[i];
      end
    end
  end

  // Delivered-word counter. It saturates at all-ones so that it never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (vld_q[4] && out_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[4];
  assign d_data    = wrd_q[4];
  assign dec_count = cnt_q;

endmodule
